// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the BNN flattening stage.
package bnn_pkg;
   localparam int unsigned NUM_INPUTS = 196;
   localparam int unsigned BEAT_W     = 14;
   localparam int unsigned BEATS      = NUM_INPUTS / BEAT_W;
   localparam int unsigned CNT_W      = $clog2(BEATS);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      SYNC = 2'd2
   } flat_state_t;
endpackage

// File: rtl/flatten_bank.sv
// One frame register: row-indexed beat write plus synchronous clear.
module flatten_bank #(
   parameter int unsigned NUM_INPUTS = 196,
   parameter int unsigned BEAT_W     = 14,
   parameter int unsigned N_BEATS    = 14,
   parameter int unsigned IDX_W      = 4
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [BEAT_W-1:0]     wr_data,
   output logic [NUM_INPUTS-1:0] data
);

   always_ff @(posedge clock) begin
      if (clear) begin
         data <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < int'(N_BEATS); k++) begin
            if (wr_idx == IDX_W'(k)) data[k*BEAT_W +: BEAT_W] <= wr_data;
         end
      end
   end

endmodule

// File: rtl/flatten_buffer.sv
// Row-beat to flat-vector assembler feeding the final dense layer.
// Optional FLATTEN_DBUF_EN: ping-pong banks so a new frame fills while one is held.
module flatten_buffer #(
   parameter int unsigned NUM_INPUTS = bnn_pkg::NUM_INPUTS,
   parameter int unsigned BEAT_W     = bnn_pkg::BEAT_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [BEAT_W-1:0]     in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [NUM_INPUTS-1:0] out_data,
   input  logic                  out_ready,
   output logic                  frame_err
);
   import bnn_pkg::*;

   localparam int unsigned N_BEATS = NUM_INPUTS / BEAT_W;
   localparam int unsigned IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

   if (N_BEATS * BEAT_W != NUM_INPUTS) begin : g_bad_geometry
      $error("flatten_buffer: NUM_INPUTS must be an exact multiple of BEAT_W");
   end

   flat_state_t       state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_d, in_ready_d, err_d;
   logic              accept, consume, last_slot, wr_en;

   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;
   assign last_slot = (cnt_q == IDX_W'(N_BEATS - 1));

`ifdef FLATTEN_DBUF_EN
   logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
`endif

   // Next-state: beat counting, framing errors and frame presentation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid;
      err_d       = 1'b0;
      wr_en       = 1'b0;
`ifdef FLATTEN_DBUF_EN
      wr_sel_d    = wr_sel_q;
      rd_sel_d    = rd_sel_q;
`endif
      if (consume) out_valid_d = 1'b0;

      case (state_q)
         FILL: begin
            if (accept) begin
               wr_en = 1'b1;
               if (last_slot && in_last) begin
                  cnt_d = '0;
`ifdef FLATTEN_DBUF_EN
                  if (!out_valid || consume) begin
                     rd_sel_d    = wr_sel_q;
                     wr_sel_d    = ~wr_sel_q;
                     out_valid_d = 1'b1;
                  end else begin
                     state_d = HOLD;
                  end
`else
                  state_d     = HOLD;
                  out_valid_d = 1'b1;
`endif
               end else if (in_last) begin
                  err_d = 1'b1;
                  cnt_d = '0;
               end else if (last_slot) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = SYNC;
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end
         HOLD: begin
`ifdef FLATTEN_DBUF_EN
            // Completed bank waits for the held one to drain, then swaps in
            if (consume) begin
               rd_sel_d    = wr_sel_q;
               wr_sel_d    = ~wr_sel_q;
               out_valid_d = 1'b1;
               state_d     = FILL;
            end
`else
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = FILL;
               cnt_d       = '0;
            end
`endif
         end
         SYNC: begin
            if (accept && in_last) state_d = FILL;
         end
         default: begin
            state_d = FILL;
            cnt_d   = '0;
         end
      endcase

      in_ready_d = (state_d != HOLD);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= FILL;
         cnt_q     <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         out_valid <= out_valid_d;
         in_ready  <= in_ready_d;
         frame_err <= err_d;
      end
   end

`ifdef FLATTEN_DBUF_EN
   logic [NUM_INPUTS-1:0] bank0_data, bank1_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
      end
   end

   flatten_bank #(
      .NUM_INPUTS(NUM_INPUTS), .BEAT_W(BEAT_W), .N_BEATS(N_BEATS), .IDX_W(IDX_W)
   ) u_bank0 (
      .clock   (clock),
      .clear   (reset),
      .wr_en   (wr_en & ~wr_sel_q),
      .wr_idx  (cnt_q),
      .wr_data (in_data),
      .data    (bank0_data)
   );

   flatten_bank #(
      .NUM_INPUTS(NUM_INPUTS), .BEAT_W(BEAT_W), .N_BEATS(N_BEATS), .IDX_W(IDX_W)
   ) u_bank1 (
      .clock   (clock),
      .clear   (reset),
      .wr_en   (wr_en & wr_sel_q),
      .wr_idx  (cnt_q),
      .wr_data (in_data),
      .data    (bank1_data)
   );

   assign out_data = rd_sel_q ? bank1_data : bank0_data;
`else
   flatten_bank #(
      .NUM_INPUTS(NUM_INPUTS), .BEAT_W(BEAT_W), .N_BEATS(N_BEATS), .IDX_W(IDX_W)
   ) u_bank0 (
      .clock   (clock),
      .clear   (reset),
      .wr_en   (wr_en),
      .wr_idx  (cnt_q),
      .wr_data (in_data),
      .data    (out_data)
   );
`endif

endmodule

// File: tb/tb_flatten_buffer.sv
// Directed self-checking bench for flatten_buffer (FLATTEN_DBUF_EN adds the ping-pong test).
`timescale 1ns/1ps
module tb_flatten_buffer;
   localparam int NI = 196;
   localparam int BW = 14;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid, in_last, in_ready, out_valid, out_ready, frame_err;
   logic [BW-1:0] in_data;
   logic [NI-1:0] out_data;
   logic [NI-1:0] exp_data, prev_data;
   int            checks = 0;
   int            errors = 0;

   flatten_buffer dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_beat(input logic [BW-1:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_diagonal();
      exp_data = '0;
      for (int k = 0; k < 14; k++) exp_data[k*15] = 1'b1;
      for (int k = 0; k < 14; k++) begin
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL diag_early_valid beat %0d: got %b expected 0", k, out_valid); end
         send_beat(BW'(1) << k, k == 13);
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL diag_out_valid: got %b expected 1", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL diag_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL diag_data: got %h expected %h", out_data, exp_data); end
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (out_valid !== 1'b1 || out_data !== exp_data) begin
            errors++; $display("FAIL diag_hold cycle %0d: valid %b data %h expected 1 %h", c, out_valid, out_data, exp_data);
         end
      end
   endtask

   task automatic test_handshake_ones();
      consume();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_out_valid_fall: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hs_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL hs_data_kept: got %h expected %h", out_data, exp_data); end
      for (int k = 0; k < 14; k++) send_beat(14'h3FFF, k == 13);
      checks++; if (out_valid !== 1'b1 || out_data !== {NI{1'b1}}) begin
         errors++; $display("FAIL ones_frame: valid %b data %h expected all ones", out_valid, out_data);
      end
      consume();
   endtask

   task automatic test_short_frame();
      for (int k = 0; k < 6; k++) send_beat(14'h1234, k == 5);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_err: got %b expected 1", frame_err); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL short_no_valid: got %b expected 0", out_valid); end
      step();
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_err_pulse: got %b expected 0", frame_err); end
      for (int k = 0; k < 14; k++) send_beat(14'h2AAA, k == 13);
      exp_data = {14{14'h2AAA}};
      checks++; if (out_valid !== 1'b1 || out_data !== exp_data) begin
         errors++; $display("FAIL short_recover: valid %b data %h expected 1 %h", out_valid, out_data, exp_data);
      end
      consume();
   endtask

   task automatic test_long_frame();
      for (int k = 0; k < 14; k++) send_beat(14'h0555, 1'b0);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL long_err: got %b expected 1", frame_err); end
      for (int k = 0; k < 4; k++) begin
         send_beat(14'h3C3C, k == 3);
         checks++; if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL long_junk %0d: err %b valid %b expected 0 0", k, frame_err, out_valid);
         end
      end
      exp_data = '0;
      for (int k = 0; k < 14; k++) begin
         exp_data[k*14 +: 14] = 14'(k + 1);
         send_beat(14'(k + 1), k == 13);
      end
      checks++; if (out_valid !== 1'b1 || out_data !== exp_data) begin
         errors++; $display("FAIL long_recover: valid %b data %h expected 1 %h", out_valid, out_data, exp_data);
      end
      consume();
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 8; k++) send_beat(14'h1555, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
         errors++; $display("FAIL midreset_clear: valid %b data %h expected 0 0", out_valid, out_data);
      end
      exp_data = '0;
      for (int k = 0; k < 14; k++) begin
         exp_data[k*14 +: 14] = ~(BW'(1) << k);
         send_beat(~(BW'(1) << k), k == 13);
      end
      checks++; if (out_valid !== 1'b1 || out_data !== exp_data) begin
         errors++; $display("FAIL midreset_frame: valid %b data %h expected 1 %h", out_valid, out_data, exp_data);
      end
      consume();
   endtask

`ifdef FLATTEN_DBUF_EN
   task automatic test_back_to_back();
      prev_data = '0;
      for (int k = 0; k < 14; k++) begin
         prev_data[k*14 +: 14] = 14'(k);
         send_beat(14'(k), k == 13);
      end
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
         errors++; $display("FAIL dbuf_first: valid %b ready %b expected 1 1", out_valid, in_ready);
      end
      exp_data = '0;
      for (int k = 0; k < 14; k++) begin
         exp_data[k*14 +: 14] = 14'(16'h3FFF - 16'(k));
         send_beat(14'(16'h3FFF - 16'(k)), k == 13);
      end
      checks++; if (in_ready !== 1'b0 || out_data !== prev_data) begin
         errors++; $display("FAIL dbuf_stall: ready %b data %h expected 0 %h", in_ready, out_data, prev_data);
      end
      consume();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_data || in_ready !== 1'b1) begin
         errors++; $display("FAIL dbuf_swap: valid %b ready %b data %h expected 1 1 %h", out_valid, in_ready, out_data, exp_data);
      end
      consume();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dbuf_drain: got %b expected 0", out_valid); end
   endtask
`endif

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      exp_data  = '0;
      prev_data = '0;
      test_reset();
      test_diagonal();
      test_handshake_ones();
      test_short_frame();
      test_long_frame();
      test_mid_reset();
`ifdef FLATTEN_DBUF_EN
      test_back_to_back();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
